// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ accelerator blocks.
package otbn_pq_pkg;

    // Legal range of the bit-reversal index width n.
    localparam int unsigned BitrevNofBitsMin = 6;
    localparam int unsigned BitrevNofBitsMax = 12;

    typedef enum logic [3:0] {
        StIdle,
        StScan,
        StRdA,
        StWtA,
        StRdB,
        StWtB,
        StWrA,
        StWrB,
        StDone
    } bitrev_perm_state_e;

    function automatic logic bitrev_nof_bits_legal(input logic [3:0] nof_bits);
        return (32'(nof_bits) >= BitrevNofBitsMin) && (32'(nof_bits) <= BitrevNofBitsMax);
    endfunction

endpackage

// File: rtl/bitrev_idx_gen.sv
// Index counter i with its n-bit reversal rev_n(i) and a flag for i = 2^n-1.
module bitrev_idx_gen #(
    parameter int unsigned IdxW = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic [3:0]      nof_bits_i,
    output logic [IdxW-1:0] idx_o,
    output logic [IdxW-1:0] rev_o,
    output logic            last_o
);

    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] rev_full;

    // Next index: clear on start, step on request.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + IdxW'(1);
        end
    end

    // Index register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Reverse all IdxW bits, then shift down so only the low n bits remain reversed.
    always_comb begin
        rev_full = '0;
        for (int k = 0; k < IdxW; k++) begin
            rev_full[k] = idx_q[IdxW-1-k];
        end
        rev_o = rev_full >> (IdxW - 32'(nof_bits_i));
    end

    // Last index when every bit below n is set.
    assign last_o = &(idx_q | ({IdxW{1'b1}} << nof_bits_i));
    assign idx_o  = idx_q;

endmodule

// File: rtl/bitrev_permute.sv
// In-place bit-reversal permutation of 2^n 32-bit coefficients over a req/gnt memory port.
module bitrev_permute
    import otbn_pq_pkg::*;
#(
    parameter int unsigned IdxW = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  nof_bits_i,
    input  logic [31:0] base_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    bitrev_perm_state_e state_q, state_d;

    logic [3:0]      nof_bits_q;
    logic [31:0]     base_q;
    logic [31:0]     data_a_q;
    logic [31:0]     data_b_q;
    logic            err_q;

    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] rev;
    logic            last;
    logic            idx_clr;
    logic            idx_inc;
    logic            swap;
    logic            start_ok;
    logic            start_bad;
    logic [31:0]     addr_idx;
    logic [31:0]     addr_rev;

    assign start_ok  = start_i && bitrev_nof_bits_legal(nof_bits_i);
    assign start_bad = start_i && !bitrev_nof_bits_legal(nof_bits_i);
    // Each pair is handled once, from its smaller index.
    assign swap      = idx < rev;
    assign addr_idx  = base_q + (32'(idx) << 2);
    assign addr_rev  = base_q + (32'(rev) << 2);

    bitrev_idx_gen #(
        .IdxW(IdxW)
    ) u_idx_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (idx_clr),
        .inc_i      (idx_inc),
        .nof_bits_i (nof_bits_q),
        .idx_o      (idx),
        .rev_o      (rev),
        .last_o     (last)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_ok) state_d = StScan;
            StScan: begin
                if (swap) begin
                    state_d = StRdA;
                end else if (last) begin
                    state_d = StDone;
                end
            end
            StRdA:  if (mem_gnt_i) state_d = StWtA;
            StWtA:  if (mem_rvalid_i) state_d = StRdB;
            StRdB:  if (mem_gnt_i) state_d = StWtB;
            StWtB:  if (mem_rvalid_i) state_d = StWrA;
            StWrA:  if (mem_gnt_i) state_d = StWrB;
            StWrB:  if (mem_gnt_i) state_d = last ? StDone : StScan;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; request fields depend only on registered state so they hold through stalls.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        unique case (state_q)
            StIdle: idx_clr = start_ok;
            StScan: begin
                busy_o  = 1'b1;
                idx_inc = !swap && !last;
            end
            StRdA: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = addr_idx;
            end
            StRdB: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = addr_rev;
            end
            StWtA, StWtB: busy_o = 1'b1;
            StWrA: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_idx;
                mem_wdata_o = data_b_q;
            end
            StWrB: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_rev;
                mem_wdata_o = data_a_q;
                idx_inc     = mem_gnt_i && !last;
            end
            StDone: done_o = 1'b1;
            default: ;
        endcase
    end

    // Operand latches, read-data capture and the error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nof_bits_q <= 4'(BitrevNofBitsMin);
            base_q     <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && start_bad;
            if (idx_clr) begin
                nof_bits_q <= nof_bits_i;
                base_q     <= base_addr_i;
            end
            if (state_q == StWtA && mem_rvalid_i) begin
                data_a_q <= mem_rdata_i;
            end
            if (state_q == StWtB && mem_rvalid_i) begin
                data_b_q <= mem_rdata_i;
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_bitrev_permute.sv
// Directed bench for bitrev_permute with a behavioural req/gnt/rvalid memory.
module tb_bitrev_permute;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  nof_bits;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic        req;
    logic        gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    int n_cmp;
    int n_fail;

    logic [31:0] mem [logic [31:0]];
    int          rd_cnt;
    int          wr_cnt;
    int          req_cycles;
    int          err_cnt;
    int          stall_viol;
    bit          rand_mode;
    int          fixed_dly;

    bitrev_permute #(
        .IdxW(12)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .nof_bits_i   (nof_bits),
        .base_addr_i  (base_addr),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .mem_req_o    (req),
        .mem_gnt_i    (gnt),
        .mem_we_o     (we),
        .mem_addr_o   (addr),
        .mem_wdata_o  (wdata),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rev_n(input int k, input int n);
        logic [31:0] kk;
        logic [31:0] r;
        kk = 32'(k);
        r  = '0;
        for (int b = 0; b < n; b++) begin
            r[n-1-b] = kk[b];
        end
        return r;
    endfunction

    function automatic int count_bad(input int n, input logic [31:0] b);
        int          bad;
        logic [31:0] a;
        bad = 0;
        for (int k = 0; k < (1 << n); k++) begin
            a = b + 32'(k * 4);
            if (!mem.exists(a)) begin
                bad++;
            end else if (mem[a] !== rev_n(k, n)) begin
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic fill(input int n, input logic [31:0] b);
        mem.delete();
        for (int k = 0; k < (1 << n); k++) begin
            mem[b + 32'(k * 4)] = 32'(k);
        end
        rd_cnt     = 0;
        wr_cnt     = 0;
        stall_viol = 0;
        err_cnt    = 0;
    endtask

    // Memory: grant decided and transfer performed at negedge, read data returned after a delay.
    task automatic mem_model();
        bit          pend;
        int          wt;
        logic [31:0] pdata;
        bit          pstall;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwe;
        pend   = 0;
        wt     = 0;
        pdata  = '0;
        pstall = 0;
        paddr  = '0;
        pwdata = '0;
        pwe    = 1'b0;
        gnt    = 1'b1;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend   = 0;
                pstall = 0;
                gnt    = 1'b1;
                rvalid = 1'b0;
                rdata  = '0;
            end else begin
                if (pstall && (req !== 1'b1 || addr !== paddr || we !== pwe || wdata !== pwdata))
                    stall_viol++;
                rvalid = 1'b0;
                rdata  = '0;
                if (pend) begin
                    if (wt == 0) begin
                        rvalid = 1'b1;
                        rdata  = pdata;
                        pend   = 0;
                    end else begin
                        wt--;
                    end
                end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                    rvalid = 1'b1;
                    rdata  = 32'hDEAD_BEEF;
                end
                gnt = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (req) req_cycles++;
                if (err) err_cnt++;
                if (req && gnt) begin
                    if (we) begin
                        mem[addr] = wdata;
                        wr_cnt++;
                    end else begin
                        pend  = 1;
                        pdata = mem.exists(addr) ? mem[addr] : 32'hBAD0_0BAD;
                        wt    = (rand_mode ? int'($urandom_range(1, 4)) : fixed_dly) - 1;
                        rd_cnt++;
                    end
                end
                pstall = req && !gnt;
                paddr  = addr;
                pwe    = we;
                pwdata = wdata;
            end
        end
    endtask

    // Start a run and count edges from the accepting edge to the one raising done_o.
    task automatic run_perm(input logic [3:0] n, input logic [31:0] b, input bit poke,
                            output int cycles, output bit to, output logic first_busy);
        start      = 1'b1;
        nof_bits   = n;
        base_addr  = b;
        to         = 1;
        cycles     = 0;
        first_busy = 1'b0;
        for (int c = 1; c <= 40000; c++) begin
            tick();
            if (c == 1) begin
                start      = 1'b0;
                first_busy = busy;
            end
            if (poke && c == 10) begin
                start     = 1'b1;
                nof_bits  = 4'd13;
                base_addr = 32'h0BAD_0000;
            end
            if (poke && c == 11) start = 1'b0;
            if (done) begin
                cycles = c - 1;
                to     = 0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, err, req, we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, req, we});
        end
        n_cmp++;
        if (addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", addr);
        end
        n_cmp++;
        if (wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wdata: got %h want 0", wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_n6_ideal();
        int   cyc;
        bit   to;
        logic fb;
        int   bad;
        rand_mode = 0;
        fixed_dly = 1;
        fill(6, 32'h1000);
        run_perm(4'd6, 32'h1000, 1, cyc, to, fb);
        bad = count_bad(6, 32'h1000);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL n6_timeout: done_o never seen, want done after 232 cycles");
        end
        n_cmp++;
        if (fb !== 1'b1) begin
            n_fail++;
            $display("FAIL n6_busy: got %b want 1", fb);
        end
        n_cmp++;
        if (cyc != 232) begin
            n_fail++;
            $display("FAIL n6_latency: got %0d want 232", cyc);
        end
        n_cmp++;
        if (wr_cnt != 56 || rd_cnt != 56) begin
            n_fail++;
            $display("FAIL n6_swaps: got %0d writes %0d reads want 56/56 (28 swaps)",
                     wr_cnt, rd_cnt);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL n6_data: got %0d wrong words want 0", bad);
        end
        n_cmp++;
        if (mem.num() != 64) begin
            n_fail++;
            $display("FAIL n6_footprint: got %0d words want 64", mem.num());
        end
        n_cmp++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL n6_start_busy: got %0d err pulses want 0", err_cnt);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL n6_done_pulse: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_n12();
        int   cyc;
        bit   to;
        logic fb;
        int   bad;
        fill(12, 32'h0);
        run_perm(4'd12, 32'h0, 0, cyc, to, fb);
        bad = count_bad(12, 32'h0);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL n12_timeout: done_o never seen, want done");
        end
        n_cmp++;
        if (wr_cnt != 4032) begin
            n_fail++;
            $display("FAIL n12_swaps: got %0d writes want 4032 (2016 swaps)", wr_cnt);
        end
        n_cmp++;
        if (cyc != 16192) begin
            n_fail++;
            $display("FAIL n12_latency: got %0d want 16192", cyc);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL n12_data: got %0d wrong words want 0", bad);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [3:0] bad_n [2];
        int         req0;
        int         busy_seen;
        bad_n[0] = 4'd5;
        bad_n[1] = 4'd13;
        for (int j = 0; j < 2; j++) begin
            err_cnt   = 0;
            req0      = req_cycles;
            busy_seen = 0;
            start     = 1'b1;
            nof_bits  = bad_n[j];
            base_addr = 32'h3000;
            tick();
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_err_n%0d: got %b want 1", bad_n[j], err);
            end
            if (busy) busy_seen++;
            tick();
            n_cmp++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL illegal_err_width_n%0d: got %b want 0", bad_n[j], err);
            end
            for (int c = 0; c < 8; c++) begin
                if (busy) busy_seen++;
                tick();
            end
            n_cmp++;
            if (busy_seen != 0 || req_cycles != req0 || err_cnt != 1) begin
                n_fail++;
                $display("FAIL illegal_quiet_n%0d: got busy=%0d req=%0d err=%0d want 0/0/1",
                         bad_n[j], busy_seen, req_cycles - req0, err_cnt);
            end
        end
    endtask

    task automatic test_random_stalls();
        int   cyc;
        bit   to;
        logic fb;
        int   bad;
        rand_mode = 1;
        fill(8, 32'h2000_0000);
        run_perm(4'd8, 32'h2000_0000, 0, cyc, to, fb);
        bad = count_bad(8, 32'h2000_0000);
        rand_mode = 0;
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL stall_timeout: done_o never seen, want done");
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_data: got %0d wrong words want 0", bad);
        end
        n_cmp++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d changed requests want 0", stall_viol);
        end
        n_cmp++;
        if (wr_cnt != 240) begin
            n_fail++;
            $display("FAIL stall_swaps: got %0d writes want 240", wr_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit   found;
        int   cyc;
        bit   to;
        logic fb;
        int   bad;
        rand_mode = 0;
        fixed_dly = 3;
        fill(6, 32'h400);
        found     = 0;
        start     = 1'b1;
        nof_bits  = 4'd6;
        base_addr = 32'h400;
        for (int c = 0; c < 300; c++) begin
            tick();
            start = 1'b0;
            if (rd_cnt == 2) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_reach: got %0d reads want 2", rd_cnt);
        end
        tick();          // now waiting for the second read's data
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done, req, we} !== 4'b0 || addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got ctrl=%b addr=%h want 0000/0",
                     {busy, done, req, we}, addr);
        end
        rst       = 1'b0;
        fixed_dly = 1;
        tick();
        wr_cnt = 0;
        run_perm(4'd6, 32'h400, 0, cyc, to, fb);
        bad = count_bad(6, 32'h400);
        n_cmp++;
        if (to || cyc != 232) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got timeout=%0b cycles=%0d want 0/232", to, cyc);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %0d wrong words want 0", bad);
        end
        tick();
    endtask

    task automatic test_wrap();
        int          cyc;
        bit          to;
        logic        fb;
        int          bad;
        logic [31:0] w0;
        fill(6, 32'hFFFF_FFF0);
        run_perm(4'd6, 32'hFFFF_FFF0, 0, cyc, to, fb);
        bad = count_bad(6, 32'hFFFF_FFF0);
        w0  = mem.exists(32'h0) ? mem[32'h0] : 32'hFFFF_FFFF;
        n_cmp++;
        if (to || bad != 0) begin
            n_fail++;
            $display("FAIL wrap_data: got timeout=%0b bad=%0d want 0/0", to, bad);
        end
        n_cmp++;
        if (mem.num() != 64) begin
            n_fail++;
            $display("FAIL wrap_footprint: got %0d words want 64", mem.num());
        end
        // Address 0 holds index 4 after wrap; rev_6(4) = 8.
        n_cmp++;
        if (w0 !== 32'd8) begin
            n_fail++;
            $display("FAIL wrap_addr0: got %h want 00000008", w0);
        end
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        nof_bits   = 4'd0;
        base_addr  = 32'h0;
        rd_cnt     = 0;
        wr_cnt     = 0;
        req_cycles = 0;
        err_cnt    = 0;
        stall_viol = 0;
        rand_mode  = 0;
        fixed_dly  = 1;
        fork
            mem_model();
        join_none
        test_reset();
        test_n6_ideal();
        test_n12();
        test_illegal();
        test_random_stalls();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
